// File: rtl/raw_frame_streamer.sv
// Frame source: reads a row-major raw frame from memory and streams it out as
// valid/ready beats with SOF/EOL/EOF markers, optional byte swap and horizontal blanking.
module raw_frame_streamer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MAX_W  = 640,
  parameter int unsigned MAX_H  = 512,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              swap_en,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [7:0]        hblank,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned NB = DATA_W / 8;
  localparam logic [DIM_W-1:0] MaxWDim = DIM_W'(MAX_W);
  localparam logic [DIM_W-1:0] MaxHDim = DIM_W'(MAX_H);

  typedef enum logic [1:0] {StIdle, StRead, StBlank} state_e;

  state_e              state_q;
  logic [DIM_W-1:0]    w_q, h_q, col_q, row_q;
  logic [7:0]          hb_q, blank_q;
  logic                swap_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                cfg_err_q;

  // Read-data return stage: markers and swap setting of the read issued last cycle.
  logic                pend_q, pend_sof_q, pend_eol_q, pend_eof_q, pend_swap_q;

  // Two-entry buffer; head entry drives the stream outputs.
  logic [DATA_W-1:0]   buf_data_q [2];
  logic [2:0]          buf_mark_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          occ_q;
  logic [15:0]         frame_cnt_q;

  logic                cfg_ok, pop, room;
  logic [2:0]          committed;
  logic                rd_sof, rd_eol, rd_eof;
  logic [DATA_W-1:0]   swapped, cap_data;

  // Config legality of the live inputs, checked at start and at each frame wrap.
  always_comb begin
    cfg_ok = (img_w != '0) && (img_h != '0) && (img_w <= MaxWDim) && (img_h <= MaxHDim);
  end

  // Read issue: entries still held after this cycle's pop plus data returning this cycle
  // must leave a free slot for the new read, so a stall can never overflow the buffer.
  always_comb begin
    pop       = m_valid && m_ready;
    committed = 3'(occ_q) + 3'(pend_q) - 3'(pop);
    room      = committed < 3'd2;
    mem_rd    = (state_q == StRead) && room;
    rd_sof    = (col_q == '0) && (row_q == '0);
    rd_eol    = (col_q == w_q - DIM_W'(1));
    rd_eof    = rd_eol && (row_q == h_q - DIM_W'(1));
  end

  // Byte reversal of the returning word.
  always_comb begin
    swapped = '0;
    for (int k = 0; k < NB; k++) begin
      swapped[8*k +: 8] = mem_rdata[8*(NB-1-k) +: 8];
    end
    cap_data = pend_swap_q ? swapped : mem_rdata;
  end

  // Control FSM with column/row/address counters and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      w_q       <= '0;
      h_q       <= '0;
      hb_q      <= '0;
      swap_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      blank_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !busy) begin
            if (cfg_ok) begin
              w_q     <= img_w;
              h_q     <= img_h;
              hb_q    <= hblank;
              swap_q  <= swap_en;
              col_q   <= '0;
              row_q   <= '0;
              addr_q  <= '0;
              state_q <= StRead;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StRead: begin
          if (mem_rd) begin
            if (rd_eol) begin
              col_q <= '0;
              if (hb_q != 8'd0) blank_q <= hb_q - 8'd1;
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
            if (rd_eof) begin
              row_q  <= '0;
              addr_q <= '0;
              if (cont && cfg_ok) begin
                // Wrap into the next frame with freshly latched config.
                w_q     <= img_w;
                h_q     <= img_h;
                hb_q    <= hblank;
                swap_q  <= swap_en;
                state_q <= (hb_q != 8'd0) ? StBlank : StRead;
              end else begin
                // Buffered beats still drain; busy covers them.
                state_q   <= StIdle;
                cfg_err_q <= cont;
              end
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (rd_eol) begin
                row_q <= row_q + DIM_W'(1);
                if (hb_q != 8'd0) state_q <= StBlank;
              end
            end
          end
        end
        StBlank: begin
          if (blank_q == 8'd0) state_q <= StRead;
          else blank_q <= blank_q - 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Track the read in flight so its data is captured with its own markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_sof_q  <= 1'b0;
      pend_eol_q  <= 1'b0;
      pend_eof_q  <= 1'b0;
      pend_swap_q <= 1'b0;
    end else begin
      pend_q      <= mem_rd;
      pend_sof_q  <= rd_sof;
      pend_eol_q  <= rd_eol;
      pend_eof_q  <= rd_eof;
      pend_swap_q <= swap_q;
    end
  end

  // Buffer: push returning data, pop on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_mark_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (pend_q) begin
        buf_data_q[wr_ptr_q] <= cap_data;
        buf_mark_q[wr_ptr_q] <= {pend_sof_q, pend_eol_q, pend_eof_q};
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(pend_q) - 2'(pop);
    end
  end

  // Completed-frame counter, stepped when the EOF beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else if (pop && m_eof) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign mem_addr  = addr_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_data_q[rd_ptr_q];
  assign m_sof     = buf_mark_q[rd_ptr_q][2];
  assign m_eol     = buf_mark_q[rd_ptr_q][1];
  assign m_eof     = buf_mark_q[rd_ptr_q][0];
  assign busy      = (state_q != StIdle) || (occ_q != 2'd0) || pend_q;
  assign cfg_err   = cfg_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_raw_frame_streamer.sv
// Bench for raw_frame_streamer: table-driven frames, randomized frames and hand-written
// sequences for continuous mode, illegal config, start-while-busy and mid-frame reset.
module tb_raw_frame_streamer;
  localparam int DW = 16, AW = 19, DIMW = 10;

  logic            clk = 1'b0;
  logic            rst, start, cont, swap_en;
  logic [DIMW-1:0] img_w, img_h;
  logic [7:0]      hblank;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   m_data;
  logic            m_valid, m_ready, m_sof, m_eol, m_eof, busy, cfg_err;
  logic [15:0]     frame_cnt;

  raw_frame_streamer #(
    .DATA_W(16), .MAX_W(640), .MAX_H(512), .ADDR_W(19), .DIM_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .swap_en(swap_en),
    .img_w(img_w), .img_h(img_h), .hblank(hblank),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        sof, eol, eof;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    rd_addr[$];
  int    rd_cyc[$];
  int    n_checks = 0, n_fail = 0;
  int    ready_pct = 100;
  int    start_cyc = 0;
  int    fc_exp = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: collect accepted beats and issued reads, and check hold during stalls.
  logic [18:0] prev_bits;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {m_valid, m_sof, m_eol, m_eof, m_data}, {1'b1, prev_bits});
      if (m_valid && m_ready) begin
        b.data = m_data; b.sof = m_sof; b.eol = m_eol; b.eof = m_eof; b.cyc = cyc;
        beats.push_back(b);
      end
      if (mem_rd) begin
        rd_addr.push_back(int'(mem_addr));
        rd_cyc.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_bits  = {m_sof, m_eol, m_eof, m_data};
    end
  end

  function automatic logic [15:0] bswap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  task automatic fill_mem(input int pat);
    for (int i = 0; i < 4096; i++) mem[i] = (pat == 2) ? 16'($urandom) : 16'(i);
    if (pat == 1) mem[0] = 16'h1234;
  endtask

  task automatic clear_logs();
    beats.delete(); rd_addr.delete(); rd_cyc.delete();
  endtask

  task automatic step();
    if (ready_pct >= 100) m_ready = 1'b1;
    else m_ready = (int'($urandom_range(0, 99)) < ready_pct);
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h, input int hb, input bit sw);
    img_w = DIMW'(w); img_h = DIMW'(h); hblank = 8'(hb); swap_en = sw;
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Reference: frame i of nf frames is pixel idx = i mod (w*h), row-major from address 0.
  task automatic compare_frames(input int w, input int h, input bit sw, input int nf,
                                input string tag);
    int n = w * h;
    int errs = 0, aerrs = 0;
    logic [15:0] ed;
    check({tag, "_beats"}, beats.size(), n * nf);
    for (int i = 0; i < beats.size() && i < n * nf; i++) begin
      int idx = i % n;
      ed = sw ? bswap(mem[idx]) : mem[idx];
      if (beats[i].data !== ed || beats[i].sof !== (idx == 0) ||
          beats[i].eol !== ((idx % w) == w - 1) || beats[i].eof !== (idx == n - 1)) errs++;
    end
    check({tag, "_beat_errs"}, errs, 0);
    check({tag, "_reads"}, rd_addr.size(), n * nf);
    for (int i = 0; i < rd_addr.size() && i < n * nf; i++) if (rd_addr[i] != i % n) aerrs++;
    check({tag, "_addr_errs"}, aerrs, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int hb, input bit sw, input int rpct);
    int n = w * h;
    int gerr = 0;
    ready_pct = rpct;
    clear_logs();
    start_frame(w, h, hb, sw);
    wait_idle(n * (hb + 2) * 12 + 50);
    compare_frames(w, h, sw, 1, "frame");
    fc_exp++;
    check("frame_cnt", frame_cnt, 16'(fc_exp));
    if (beats.size() > 0) check("busy_fall", cyc, beats[beats.size()-1].cyc + 1);
    if (rpct >= 100 && beats.size() == n && rd_cyc.size() == n) begin
      check("first_rd_lat", rd_cyc[0], start_cyc + 1);
      check("first_valid_lat", beats[0].cyc, start_cyc + 3);
      if (hb == 0) check("back_to_back", beats[n-1].cyc - beats[0].cyc, n - 1);
      for (int k = 1; k < h; k++) if (rd_cyc[k*w] - rd_cyc[k*w-1] - 1 != hb) gerr++;
      if (h > 1) check("hblank_gap_errs", gerr, 0);
    end
  endtask

  typedef struct {
    int w, h, hb;
    bit sw;
    int rpct, pat, exp_beats;
    logic [15:0] exp_first, exp_last;
  } vec_t;

  vec_t vecs[9];

  typedef struct { int w, h; } bad_t;
  bad_t bad[4];

  initial begin
    void'($urandom(32'h5EED_1234));
    vecs[0] = '{4,   3,   0, 1'b0, 100, 0, 12,  16'h0000, 16'h000B};
    vecs[1] = '{4,   3,   0, 1'b0, 50,  0, 12,  16'h0000, 16'h000B};
    vecs[2] = '{4,   2,   3, 1'b0, 100, 0, 8,   16'h0000, 16'h0007};
    vecs[3] = '{4,   2,   0, 1'b1, 100, 1, 8,   16'h3412, 16'h0700};
    vecs[4] = '{4,   2,   0, 1'b0, 100, 1, 8,   16'h1234, 16'h0007};
    vecs[5] = '{1,   1,   0, 1'b0, 100, 0, 1,   16'h0000, 16'h0000};
    vecs[6] = '{1,   1,   2, 1'b1, 30,  1, 1,   16'h3412, 16'h3412};
    vecs[7] = '{640, 1,   0, 1'b0, 100, 0, 640, 16'h0000, 16'h027F};
    vecs[8] = '{1,   512, 1, 1'b0, 100, 0, 512, 16'h0000, 16'h01FF};
    bad[0] = '{0, 3}; bad[1] = '{641, 3}; bad[2] = '{4, 0}; bad[3] = '{4, 513};

    rst = 1'b1; start = 1'b0; cont = 1'b0; swap_en = 1'b0;
    img_w = '0; img_h = '0; hblank = '0; m_ready = 1'b1;
    fill_mem(0);
    repeat (3) step();
    check("reset_outputs", {mem_rd, mem_addr, m_data, m_valid, m_sof, m_eol, m_eof, busy,
                            cfg_err, frame_cnt}, 64'd0);
    rst = 1'b0;
    step();

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      fill_mem(vecs[v].pat);
      run_frame(vecs[v].w, vecs[v].h, vecs[v].hb, vecs[v].sw, vecs[v].rpct);
      check("vec_beats", beats.size(), vecs[v].exp_beats);
      if (beats.size() > 0) begin
        check("vec_first_data", beats[0].data, vecs[v].exp_first);
        check("vec_last_data", beats[beats.size()-1].data, vecs[v].exp_last);
      end
    end

    // Randomized frames against the reference.
    for (int r = 0; r < 8; r++) begin
      fill_mem(2);
      run_frame($urandom_range(1, 9), $urandom_range(1, 6), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), $urandom_range(30, 100));
    end

    // Continuous 2x2: two full frames, then drop cont during frame 3.
    begin
      int k = 0;
      fill_mem(0);
      ready_pct = 100;
      clear_logs();
      cont = 1'b1;
      start_frame(2, 2, 0, 1'b0);
      while (beats.size() < 8 && k < 200) begin step(); k++; end
      check("cont_8_beats_timeout", beats.size() >= 8, 1);
      check("cont_frame_cnt_2", frame_cnt, 16'(fc_exp + 2));
      cont = 1'b0;
      wait_idle(200);
      compare_frames(2, 2, 1'b0, 3, "cont");
      fc_exp += 3;
      check("cont_frame_cnt_3", frame_cnt, 16'(fc_exp));
    end

    // Illegal configurations.
    for (int b = 0; b < 4; b++) begin
      clear_logs();
      img_w = DIMW'(bad[b].w); img_h = DIMW'(bad[b].h);
      start = 1'b1;
      step();
      start = 1'b0;
      check("cfg_err_pulse", {cfg_err, busy}, 2'b10);
      step();
      check("cfg_err_clear", cfg_err, 0);
      repeat (3) step();
      check("cfg_err_no_reads", rd_addr.size(), 0);
    end

    // Start while busy is ignored, including its config.
    fill_mem(0);
    ready_pct = 100;
    clear_logs();
    start_frame(4, 3, 0, 1'b0);
    step();
    img_w = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_no_err", cfg_err, 0);
    wait_idle(200);
    compare_frames(4, 3, 1'b0, 1, "busy_start");
    fc_exp++;
    check("busy_start_frame_cnt", frame_cnt, 16'(fc_exp));

    // Reset mid-frame, then replay from address 0.
    begin
      int k = 0;
      clear_logs();
      start_frame(4, 3, 0, 1'b0);
      while (beats.size() < 5 && k < 50) begin step(); k++; end
      check("rst_wait_timeout", beats.size() >= 5, 1);
      rst = 1'b1;
      step();
      check("midframe_reset_outputs", {mem_rd, mem_addr, m_data, m_valid, m_sof, m_eol, m_eof,
                                       busy, cfg_err, frame_cnt}, 64'd0);
      rst = 1'b0;
      fc_exp = 0;
      step();
      clear_logs();
      start_frame(4, 3, 0, 1'b0);
      wait_idle(200);
      compare_frames(4, 3, 1'b0, 1, "replay");
      fc_exp++;
      check("replay_frame_cnt", frame_cnt, 16'(fc_exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
